// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ctrl_pkg                                                         |
// | Shared types and constants for the MEM-stage access controller.      |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
package mem_ctrl_pkg;

  localparam int c_ADDR_W    = 64;
  localparam int c_DATA_W    = 64;
  localparam int c_TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl_if                                                   |
// | Data-memory req/ack bus between the controller and the memory.       |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic              DMEM_REQ;
  logic              DMEM_WE;
  logic [ADDR_W-1:0] DMEM_ADDR;
  logic [DATA_W-1:0] DMEM_WDATA;
  logic              DMEM_ACK;
  logic [DATA_W-1:0] DMEM_RDATA;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    input  DMEM_ACK, DMEM_RDATA
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    output DMEM_ACK, DMEM_RDATA
  );

endinterface
`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_timeout_cnt                                                      |
// | Clear/enable counter flagging the TERMINAL-th enabled cycle.         |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module mem_timeout_cnt #(
  parameter int WIDTH    = 16,
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Asserted during the enabled cycle in which the count reaches TERMINAL.
  assign o_tc = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl                                                      |
// | MEM-stage load/store sequencer with pipeline stall and bubble.       |
// | Optional macro MEM_ACCESS_TIMEOUT_EN adds the WAIT timeout/ERR path. |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W,
  parameter int DATA_W      = c_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_READ_IN,
  input  logic              MEM_WRITE_IN,
  input  logic              FLUSH,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WDATA_IN,
  mem_access_ctrl_if.master dmem,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic              STALL,
  output logic              BUBBLE,
  output logic              FAULT
);

  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_killed;

  logic w_op;
  logic w_start;
  logic w_stall;

  assign w_op    = MEM_READ_IN | MEM_WRITE_IN;
  assign w_start = (r_state == IDLE) && w_op && !FLUSH;
  assign w_stall = w_start || (r_state == WAIT) || (r_state == ERR);

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic w_tc;
  logic r_fault;

  mem_timeout_cnt #(
    .WIDTH    (c_TMO_CNT_W),
    .TERMINAL (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_clr (w_start),
    .i_en  ((r_state == WAIT) && !dmem.DMEM_ACK),
    .o_tc  (w_tc)
  );

  assign FAULT = r_fault;
`else
  // TIMEOUT_CYC is at least 1, so this ties FAULT low.
  assign FAULT = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_killed <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr  <= ADDR_IN;
            r_wdata <= WDATA_IN;
            r_we    <= MEM_WRITE_IN;
            r_req   <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // A squashed access still runs to completion; only its writeback is dropped.
          if (FLUSH) begin
            r_killed <= 1'b1;
          end
          if (dmem.DMEM_ACK) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_rdata <= dmem.DMEM_RDATA;
            end
            r_state <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (w_tc) begin
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            r_state <= ERR;
          end
`endif
        end
        DONE: begin
          r_killed <= 1'b0;
          r_state  <= IDLE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        ERR: begin
          r_state <= ERR;
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dmem.DMEM_REQ   = r_req;
  assign dmem.DMEM_WE    = r_we;
  assign dmem.DMEM_ADDR  = r_addr;
  assign dmem.DMEM_WDATA = r_wdata;
  assign RDATA_OUT       = r_rdata;
  assign STALL           = w_stall;
  assign BUBBLE          = w_stall || ((r_state == DONE) && r_killed);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl                                                   |
// | Directed self-checking bench for mem_access_ctrl.                    |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic        flush;
  logic [63:0] addr_in;
  logic [63:0] wdata_in;
  logic [63:0] rdata_out;
  logic        stall;
  logic        bubble;
  logic        fault;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl_if #(.ADDR_W(64), .DATA_W(64)) dmem_if ();

  mem_access_ctrl #(
    .ADDR_W      (64),
    .DATA_W      (64),
    .TIMEOUT_CYC (4)
  ) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .MEM_READ_IN  (mem_read),
    .MEM_WRITE_IN (mem_write),
    .FLUSH        (flush),
    .ADDR_IN      (addr_in),
    .WDATA_IN     (wdata_in),
    .dmem         (dmem_if),
    .RDATA_OUT    (rdata_out),
    .STALL        (stall),
    .BUBBLE       (bubble),
    .FAULT        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    flush     = 1'b0;
    dmem_if.DMEM_ACK = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dmem_if.DMEM_REQ, dmem_if.DMEM_WE, dmem_if.DMEM_ADDR, dmem_if.DMEM_WDATA} !== 130'd0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h expected all 0",
               dmem_if.DMEM_REQ, dmem_if.DMEM_WE, dmem_if.DMEM_ADDR, dmem_if.DMEM_WDATA);
    end
    checks++;
    if ({rdata_out, fault, stall, bubble} !== 67'd0) begin
      errors++;
      $display("FAIL reset_out: got rdata=%h fault=%b stall=%b bubble=%b expected all 0",
               rdata_out, fault, stall, bubble);
    end
  endtask

  task automatic test_load_zero_wait();
    mem_read = 1'b1; addr_in = 64'h40;
    #1;
    checks++;
    if ({stall, bubble, dmem_if.DMEM_REQ} !== 3'b110) begin
      errors++;
      $display("FAIL ld_idle: got stall,bubble,req=%b expected 110", {stall, bubble, dmem_if.DMEM_REQ});
    end
    tick();
    checks++;
    if ({dmem_if.DMEM_REQ, dmem_if.DMEM_WE, stall} !== 3'b101 || dmem_if.DMEM_ADDR !== 64'h40) begin
      errors++;
      $display("FAIL ld_wait: got req,we,stall=%b addr=%h expected 101 addr=40",
               {dmem_if.DMEM_REQ, dmem_if.DMEM_WE, stall}, dmem_if.DMEM_ADDR);
    end
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'hDEAD_BEEF;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    #1;
    checks++;
    if (rdata_out !== 64'hDEAD_BEEF || {dmem_if.DMEM_REQ, stall, bubble} !== 3'b000) begin
      errors++;
      $display("FAIL ld_done: got rdata=%h req,stall,bubble=%b expected deadbeef 000",
               rdata_out, {dmem_if.DMEM_REQ, stall, bubble});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({stall, bubble} !== 2'b00) begin
      errors++;
      $display("FAIL ld_after: got stall,bubble=%b expected 00", {stall, bubble});
    end
  endtask

  task automatic test_store_wait();
    int stall_cyc = 0;
    mem_write = 1'b1; addr_in = 64'h80; wdata_in = 64'h1234;
    dmem_if.DMEM_RDATA = 64'h5555;
    #1;
    if (stall) stall_cyc++;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dmem_if.DMEM_REQ, dmem_if.DMEM_WE} !== 2'b11 || dmem_if.DMEM_WDATA !== 64'h1234
          || dmem_if.DMEM_ADDR !== 64'h80) begin
        errors++;
        $display("FAIL st_wait%0d: got req,we=%b wdata=%h addr=%h expected 11 1234 80",
                 i, {dmem_if.DMEM_REQ, dmem_if.DMEM_WE}, dmem_if.DMEM_WDATA, dmem_if.DMEM_ADDR);
      end
      if (stall) stall_cyc++;
      if (i == 2) dmem_if.DMEM_ACK = 1'b1;
      tick();
    end
    dmem_if.DMEM_ACK = 1'b0;
    #1;
    if (stall) stall_cyc++;
    checks++;
    if (stall_cyc !== 4 || dmem_if.DMEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL st_stall: got stall cycles=%0d req=%b expected 4 0", stall_cyc, dmem_if.DMEM_REQ);
    end
    checks++;
    if (rdata_out !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL st_rdata: got %h expected deadbeef", rdata_out);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_read_write_both();
    mem_read = 1'b1; mem_write = 1'b1; addr_in = 64'h88; wdata_in = 64'h99;
    dmem_if.DMEM_RDATA = 64'hAAAA;
    tick();
    checks++;
    if (dmem_if.DMEM_WE !== 1'b1 || dmem_if.DMEM_WDATA !== 64'h99) begin
      errors++;
      $display("FAIL both_we: got we=%b wdata=%h expected 1 99", dmem_if.DMEM_WE, dmem_if.DMEM_WDATA);
    end
    dmem_if.DMEM_ACK = 1'b1;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    checks++;
    if (rdata_out !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL both_rdata: got %h expected deadbeef", rdata_out);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    mem_read = 1'b1; flush = 1'b1; addr_in = 64'h100;
    #1;
    checks++;
    if ({stall, bubble} !== 2'b00) begin
      errors++;
      $display("FAIL fl_idle: got stall,bubble=%b expected 00", {stall, bubble});
    end
    tick();
    checks++;
    if (dmem_if.DMEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL fl_noreq: got req=%b expected 0", dmem_if.DMEM_REQ);
    end
    flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'hCAFE;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    #1;
    checks++;
    if ({stall, bubble} !== 2'b01 || rdata_out !== 64'hCAFE) begin
      errors++;
      $display("FAIL fl_done: got stall,bubble=%b rdata=%h expected 01 cafe", {stall, bubble}, rdata_out);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bubble !== 1'b0) begin
      errors++;
      $display("FAIL fl_after: got bubble=%b expected 0", bubble);
    end
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; addr_in = 64'h200;
    tick();
    rst_n = 1'b0;
    mem_read = 1'b0;
    #1;
    checks++;
    if ({dmem_if.DMEM_REQ, stall, bubble} !== 3'b000 || dmem_if.DMEM_ADDR !== 64'h0 || rdata_out !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid: got req,stall,bubble=%b addr=%h rdata=%h expected 000 0 0",
               {dmem_if.DMEM_REQ, stall, bubble}, dmem_if.DMEM_ADDR, rdata_out);
    end
    #1;
    rst_n = 1'b1;
    tick();
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'h77;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    #1;
    checks++;
    if ({dmem_if.DMEM_REQ, stall, bubble} !== 3'b000 || rdata_out !== 64'h0) begin
      errors++;
      $display("FAIL rst_stray_ack: got req,stall,bubble=%b rdata=%h expected 000 0",
               {dmem_if.DMEM_REQ, stall, bubble}, rdata_out);
    end
  endtask

  task automatic test_back_to_back();
    mem_read = 1'b1; addr_in = 64'h300;
    tick();
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'h11;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    tick();
    addr_in = 64'h308;
    #1;
    checks++;
    if ({stall, dmem_if.DMEM_REQ} !== 2'b10 || rdata_out !== 64'h11) begin
      errors++;
      $display("FAIL b2b_idle: got stall,req=%b rdata=%h expected 10 11", {stall, dmem_if.DMEM_REQ}, rdata_out);
    end
    tick();
    checks++;
    if (dmem_if.DMEM_REQ !== 1'b1 || dmem_if.DMEM_ADDR !== 64'h308) begin
      errors++;
      $display("FAIL b2b_req2: got req=%b addr=%h expected 1 308", dmem_if.DMEM_REQ, dmem_if.DMEM_ADDR);
    end
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'h22;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({stall, bubble} !== 2'b00 || rdata_out !== 64'h22) begin
      errors++;
      $display("FAIL b2b_alu: got stall,bubble=%b rdata=%h expected 00 22", {stall, bubble}, rdata_out);
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    mem_read = 1'b1; addr_in = 64'h400;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dmem_if.DMEM_REQ, fault} !== 2'b10) begin
        errors++;
        $display("FAIL tmo_wait%0d: got req,fault=%b expected 10", i, {dmem_if.DMEM_REQ, fault});
      end
      tick();
    end
    mem_read = 1'b0;
    dmem_if.DMEM_ACK = 1'b1;
    #1;
    checks++;
    if ({fault, dmem_if.DMEM_REQ, stall, bubble} !== 4'b1011) begin
      errors++;
      $display("FAIL tmo_err: got fault,req,stall,bubble=%b expected 1011",
               {fault, dmem_if.DMEM_REQ, stall, bubble});
    end
    tick();
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    checks++;
    if ({fault, stall} !== 2'b11) begin
      errors++;
      $display("FAIL tmo_hold: got fault,stall=%b expected 11", {fault, stall});
    end
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mem_read = 1'b1; addr_in = 64'h408;
    tick();
    for (int i = 0; i < 3; i++) tick();
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 64'h33;
    tick();
    dmem_if.DMEM_ACK = 1'b0;
    #1;
    checks++;
    if ({fault, stall} !== 2'b00 || rdata_out !== 64'h33) begin
      errors++;
      $display("FAIL tmo_ack_wins: got fault,stall=%b rdata=%h expected 00 33", {fault, stall}, rdata_out);
    end
    tick();
    idle_inputs();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    addr_in  = '0;
    wdata_in = '0;
    dmem_if.DMEM_RDATA = '0;
    #11;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_load_zero_wait();
    test_store_wait();
    test_read_write_both();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the data-memory access of the MEM stage for loads (LDUR) and stores (STUR) against a multi-cycle data memory with a req/ack handshake.
- Stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM hold) while an access is outstanding.
- Forces a bubble into the MEM/WB register until the access completes.
- Presents the captured load data to the MEM/WB MEM_DATA input.

Parameters:
- ADDR_W, 64, data-memory address width.
- DATA_W, 64, data-memory word width.
- TIMEOUT_CYC, 255, WAIT cycles without ack before fault (used only with the optional feature); range 1..65535.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MEM_READ_IN  in  1  EX/MEM instruction is a load.
- MEM_WRITE_IN  in  1  EX/MEM instruction is a store.
- FLUSH  in  1  EX/MEM instruction is squashed (branch taken).
- ADDR_IN  in  ADDR_W  effective address from the ALU.
- WDATA_IN  in  DATA_W  store data.
- DMEM_REQ  out  1  memory request, registered.
- DMEM_WE  out  1  1 = write, registered.
- DMEM_ADDR  out  ADDR_W  registered address.
- DMEM_WDATA  out  DATA_W  registered store data.
- DMEM_ACK  in  1  memory completion strobe.
- DMEM_RDATA  in  DATA_W  read data, valid with DMEM_ACK on a read.
- RDATA_OUT  out  DATA_W  latched load data, registered.
- STALL  out  1  hold PC and all upstream pipeline registers; combinational.
- BUBBLE  out  1  force REGWRITE/MEM2REG to 0 into MEM/WB; combinational.
- FAULT  out  1  sticky memory-timeout flag; constant 0 without the macro.

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE; DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, RDATA_OUT and FAULT are 0. Reset mid-access abandons the transaction; no ack is awaited afterwards.
- States: IDLE, WAIT, DONE, ERR (ERR exists only with the macro).
- Op = MEM_READ_IN | MEM_WRITE_IN.
- If both inputs are set, the access is a write and the read is ignored.
- IDLE:
  - Op & !FLUSH: capture ADDR_IN/WDATA_IN into DMEM_ADDR/DMEM_WDATA; DMEM_WE=MEM_WRITE_IN; DMEM_REQ<=1; go to WAIT.
  - Otherwise: no action; the pipeline flows.
- WAIT:
  - DMEM_REQ, DMEM_WE, DMEM_ADDR and DMEM_WDATA stay stable.
  - On DMEM_ACK=1: DMEM_REQ<=0; for a read, RDATA_OUT<=DMEM_RDATA; go to DONE.
  - An ack in the first WAIT cycle is legal (zero-wait memory).
- DONE: one cycle; op inputs are ignored (they still show the same, held instruction); go to IDLE unconditionally.
- STALL = (IDLE & Op & !FLUSH) | WAIT | ERR. STALL is low in DONE, so the pipeline advances at the end of DONE.
- BUBBLE = STALL | (DONE & killed).
  - killed is a registered flag: set when FLUSH=1 in WAIT, cleared on entry to IDLE.
  - A flushed access is never aborted. It completes normally, its result is discarded, and RDATA_OUT is still updated.
- RDATA_OUT changes only on a read ack; writes leave it unchanged.
- Latency for a memory op entering IDLE at cycle t with ack at t+1+k: STALL high t..t+1+k; DONE at t+2+k; total MEM occupancy 3+k cycles.
- A DMEM_ACK outside WAIT is ignored.
- Non-memory instructions: zero added latency; STALL and BUBBLE stay low.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYC: DMEM_REQ<=0, FAULT<=1, go to ERR.
  - ERR holds STALL=1 and BUBBLE=1 until reset; FAULT stays set.
  - An ack in the same cycle the count reaches TIMEOUT_CYC wins and goes to DONE.
- Undefined: WAIT lasts indefinitely; FAULT is tied to 0; no counter logic.

Decomposition:
- Package mem_ctrl_pkg: state enum (IDLE, WAIT, DONE, ERR; 2-bit encoding), default ADDR_W/DATA_W constants, timeout counter width (16).
- One sub-module, mem_timeout_cnt: clear/enable/terminal-count counter, instantiated only under MEM_ACCESS_TIMEOUT_EN.

Test Plan:
- Load, zero-wait: MEM_READ_IN=1, ADDR_IN=0x40, ack in first WAIT cycle with RDATA=0xDEAD_BEEF -> STALL high 2 cycles, DMEM_WE=0, DMEM_ADDR=0x40, RDATA_OUT=0xDEADBEEF in DONE, BUBBLE low in DONE.
- Store, 3-cycle wait: MEM_WRITE_IN=1, WDATA=0x1234 -> DMEM_REQ high 3 cycles with stable DMEM_WE=1 and DMEM_WDATA=0x1234, STALL 4 cycles, RDATA_OUT unchanged.
- Flush: FLUSH in IDLE with load -> no DMEM_REQ, STALL low. FLUSH during WAIT -> access completes, BUBBLE=1 in DONE.
- Reset: RESET_N low during WAIT -> all outputs 0 immediately; a later stray DMEM_ACK is ignored in IDLE.
- Back-to-back: two loads in consecutive instructions -> second REQ asserted the cycle after DONE; ALU op between them sees STALL=0.
- Timeout (macro on, TIMEOUT_CYC=4), no ack -> FAULT=1 after 4 WAIT cycles, DMEM_REQ drops, STALL stays 1 until reset.
